// File: rtl/reg_si_pkg.sv
// Shared definitions for the register Simple Interface (reg_si) bus.
//   - reg_si_state_e : initiator frame-assembly states
//   - Default*Width  : default register bus widths, shared with all register slaves
//   - RegAddr*       : register address map
package reg_si_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,  // waiting for an address word
    StData  = 2'd1,  // collecting data words, LSB first
    StIssue = 2'd2   // one-cycle write strobe on the register bus
  } reg_si_state_e;

  localparam int unsigned DefaultRegDataWidth = 16;
  localparam int unsigned DefaultRegAddrWidth = 8;

  // Register address map
  localparam logic [DefaultRegAddrWidth-1:0] RegAddrAdcCtrl    = 8'h00;
  localparam logic [DefaultRegAddrWidth-1:0] RegAddrAdcThresh  = 8'h01;
  localparam logic [DefaultRegAddrWidth-1:0] RegAddrAdcConfig  = 8'h02;
  localparam logic [DefaultRegAddrWidth-1:0] RegAddrAdcDecim   = 8'h03;
  localparam logic [DefaultRegAddrWidth-1:0] RegAddrTrigCtrl   = 8'h10;
  localparam logic [DefaultRegAddrWidth-1:0] RegAddrTrigLevel  = 8'h11;
  localparam logic [DefaultRegAddrWidth-1:0] RegAddrDebugLeds  = 8'hF0;

endpackage

// File: rtl/reg_si_timeout.sv
// Loadable down-counter with clear and expiry pulse, for stream front ends that
// must drop a partial frame after too many idle cycles.
//   clk_i    : clock, rising edge
//   rst      : synchronous active-low reset
//   clr_i    : reload the counter (activity seen, or not collecting)
//   en_i     : count one idle cycle
//   expire_o : combinational; high in the Cycles-th consecutive enabled cycle
module reg_si_timeout #(
  parameter int unsigned Cycles = 1000000  // must be >= 2
) (
  input  logic clk_i,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(Cycles);
  localparam logic [CntW-1:0] LoadVal = CntW'(Cycles - 1);

  // Holds the number of idle cycles still allowed; LoadVal means none elapsed.
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      cnt_q <= LoadVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i & (cnt_q == '0);

endmodule

// File: rtl/reg_si_master.sv
// Initiator side of the register Simple Interface bus. Assembles a host byte
// stream (address word, then REG_DATA_WIDTH/RX_WIDTH data words, LSB first) into
// one register write strobe per frame. Partial frames are dropped after
// TIMEOUT_CYCLES idle cycles.
//   clk_i       : clock, rising edge
//   rst         : synchronous active-low reset
//   rx_data_i   : incoming stream word, held by the source until acked
//   rx_rdy_i    : rx_data_i valid
//   rx_ack_o    : word accepted this cycle (low during the issue cycle)
//   reg_si_data : register write data, updated only when a write is issued
//   reg_si_addr : register write address, updated only when a write is issued
//   reg_si_rdy  : one-cycle write strobe
//   busy_o      : frame partially received or being issued
//   timeout_o   : one-cycle pulse when a partial frame is dropped
module reg_si_master
  import reg_si_pkg::*;
#(
  parameter int unsigned RX_WIDTH       = 8,
  parameter int unsigned REG_DATA_WIDTH = DefaultRegDataWidth,  // multiple of RX_WIDTH
  parameter int unsigned REG_ADDR_WIDTH = DefaultRegAddrWidth,  // <= RX_WIDTH
  parameter int unsigned TIMEOUT_CYCLES = 1000000                // >= 2
) (
  input  logic                      clk_i,
  input  logic                      rst,
  input  logic [RX_WIDTH-1:0]       rx_data_i,
  input  logic                      rx_rdy_i,
  output logic                      rx_ack_o,
  output logic [REG_DATA_WIDTH-1:0] reg_si_data,
  output logic [REG_ADDR_WIDTH-1:0] reg_si_addr,
  output logic                      reg_si_rdy,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int unsigned NB    = REG_DATA_WIDTH / RX_WIDTH;
  localparam int unsigned BcntW = (NB > 1) ? $clog2(NB) : 1;

  reg_si_state_e             state_q, state_d;
  logic [BcntW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [REG_ADDR_WIDTH-1:0] shadow_addr_q, shadow_addr_d;
  logic [REG_DATA_WIDTH-1:0] shadow_data_q, shadow_data_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_DATA_WIDTH-1:0] data_q, data_d;

  logic xfer;
  logic last_byte;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_expire;

  assign rx_ack_o  = rx_rdy_i & ((state_q == StIdle) | (state_q == StData));
  assign xfer      = rx_rdy_i & rx_ack_o;
  assign last_byte = (byte_cnt_q == BcntW'(NB - 1));

  // Idle-gap counter only runs while collecting data; any accepted word restarts it.
  assign tmo_clr = (state_q != StData) | xfer;
  assign tmo_en  = (state_q == StData) & ~xfer;

  reg_si_timeout #(
    .Cycles (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst      (rst),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shadow_addr_d = shadow_addr_q;
    shadow_data_d = shadow_data_q;
    addr_d        = addr_q;
    data_d        = data_q;

    case (state_q)
      StIdle: begin
        if (xfer) begin
          shadow_addr_d = rx_data_i[REG_ADDR_WIDTH-1:0];
          byte_cnt_d    = '0;
          state_d       = StData;
        end
      end
      StData: begin
        if (xfer) begin
          for (int unsigned k = 0; k < NB; k++) begin
            if (byte_cnt_q == BcntW'(k)) begin
              shadow_data_d[k*RX_WIDTH +: RX_WIDTH] = rx_data_i;
            end
          end
          if (last_byte) begin
            // Bus outputs take the completed frame, including the word arriving now.
            addr_d  = shadow_addr_q;
            data_d  = shadow_data_d;
            state_d = StIssue;
          end else begin
            byte_cnt_d = byte_cnt_q + BcntW'(1);
          end
        end else if (tmo_expire) begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state_q       <= StIdle;
      byte_cnt_q    <= '0;
      shadow_addr_q <= '0;
      shadow_data_q <= '0;
      addr_q        <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shadow_addr_q <= shadow_addr_d;
      shadow_data_q <= shadow_data_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
    end
  end

  assign reg_si_addr = addr_q;
  assign reg_si_data = data_q;
  assign reg_si_rdy  = (state_q == StIssue);
  assign busy_o      = (state_q != StIdle);
  assign timeout_o   = tmo_expire;

endmodule

// File: tb/tb_reg_si_master.sv
module tb_reg_si_master;

  localparam int unsigned RxW   = 8;
  localparam int unsigned DataW = 16;
  localparam int unsigned AddrW = 4;
  localparam int unsigned Tmo   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [RxW-1:0]   rx_data;
  logic             rx_rdy;
  logic             rx_ack;
  logic [DataW-1:0] reg_si_data;
  logic [AddrW-1:0] reg_si_addr;
  logic             reg_si_rdy;
  logic             busy;
  logic             timeout;

  always #5 clk = ~clk;

  reg_si_master #(
    .RX_WIDTH       (RxW),
    .REG_DATA_WIDTH (DataW),
    .REG_ADDR_WIDTH (AddrW),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk_i       (clk),
    .rst         (rst),
    .rx_data_i   (rx_data),
    .rx_rdy_i    (rx_rdy),
    .rx_ack_o    (rx_ack),
    .reg_si_data (reg_si_data),
    .reg_si_addr (reg_si_addr),
    .reg_si_rdy  (reg_si_rdy),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus observer, sampled mid-cycle
  int               strobes  = 0;
  int               touts    = 0;
  int               stalls   = 0;
  int               ack_mism = 0;
  int               t_cyc    = 0;
  logic [AddrW-1:0] s_addr_q[$];
  logic [DataW-1:0] s_data_q[$];
  int               s_cyc_q[$];

  always @(negedge clk) begin
    if (reg_si_rdy) begin
      strobes++;
      s_addr_q.push_back(reg_si_addr);
      s_data_q.push_back(reg_si_data);
      s_cyc_q.push_back(cyc);
    end
    if (timeout) begin
      touts++;
      t_cyc = cyc;
    end
    if (rx_rdy && !rx_ack) stalls++;
    // With a word offered, ack must be low exactly when the strobe is high.
    if (rst && rx_rdy && (rx_ack === reg_si_rdy)) ack_mism++;
  end

  int last_ack = 0;
  int base, tbase, sbase, mbase, a_cyc, busy_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one word and return one step after the edge that accepts it.
  task automatic send(input logic [RxW-1:0] b);
    bit got;
    got     = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = rx_ack;
      if (got) last_ack = cyc;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_asserts++;
      n_fail++;
      $error("FAIL ack_wait: word 0x%0h observed no ack expected ack within 10 cycles", b);
    end
  endtask

  task automatic idle(input int n);
    rx_rdy = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap_busy(input int n);
    rx_rdy = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!busy) busy_bad++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation observed no end expected end before 100000 time units");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    rx_rdy  = 1'b0;
    rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy",     reg_si_rdy,  1'b0);
    check("rst_busy",    busy,        1'b0);
    check("rst_timeout", timeout,     1'b0);
    check("rst_addr",    reg_si_addr, 4'h0);
    check("rst_data",    reg_si_data, 16'h0000);
    check("rst_ack",     rx_ack,      1'b0);
    rst = 1'b1;
    idle(2);

    // Single write
    base = strobes;
    send(8'h02);
    send(8'h05);
    send(8'h00);
    check("t1_rdy",       reg_si_rdy,  1'b1);
    check("t1_addr",      reg_si_addr, 4'h2);
    check("t1_data",      reg_si_data, 16'h0005);
    check("t1_ack_issue", rx_ack,      1'b0);
    idle(3);
    check("t1_rdy_after", reg_si_rdy,  1'b0);
    check("t1_addr_hold", reg_si_addr, 4'h2);
    check("t1_data_hold", reg_si_data, 16'h0005);
    check("t1_strobes",   strobes - base, 1);
    check("t1_latency",   s_cyc_q[base], last_ack + 1);

    // Back-to-back frames
    base  = strobes;
    sbase = stalls;
    mbase = ack_mism;
    send(8'h00);
    send(8'h34);
    send(8'h12);
    send(8'h01);
    send(8'h78);
    send(8'h56);
    idle(3);
    check("t2_strobes", strobes - base, 2);
    check("t2_addr0",   s_addr_q[base],     4'h0);
    check("t2_data0",   s_data_q[base],     16'h1234);
    check("t2_addr1",   s_addr_q[base + 1], 4'h1);
    check("t2_data1",   s_data_q[base + 1], 16'h5678);
    check("t2_spacing", s_cyc_q[base + 1] - s_cyc_q[base], 4);
    check("t2_stalls",  stalls - sbase, 1);
    check("t2_ack_vs_issue", ack_mism - mbase, 0);

    // Timeout drops a partial frame
    base  = strobes;
    tbase = touts;
    send(8'h02);
    send(8'hAA);
    a_cyc = last_ack;
    idle(20);
    check("t3_touts",      touts - tbase, 1);
    check("t3_tout_cycle", t_cyc, a_cyc + 16);
    check("t3_no_strobe",  strobes - base, 0);
    check("t3_busy",       busy, 1'b0);
    send(8'h01);
    send(8'h03);
    send(8'h00);
    idle(2);
    check("t3_strobes", strobes - base, 1);
    check("t3_addr",    s_addr_q[base], 4'h1);
    check("t3_data",    s_data_q[base], 16'h0003);

    // Word arriving in the threshold cycle wins over the timeout
    base  = strobes;
    tbase = touts;
    send(8'h02);
    idle(15);
    send(8'h22);
    send(8'h11);
    idle(2);
    check("t3b_touts",   touts - tbase, 0);
    check("t3b_strobes", strobes - base, 1);
    check("t3b_addr",    s_addr_q[base], 4'h2);
    check("t3b_data",    s_data_q[base], 16'h1122);

    // Gapped input
    base     = strobes;
    tbase    = touts;
    busy_bad = 0;
    send(8'h02);
    check("t4_busy_first", busy, 1'b1);
    gap_busy(5);
    send(8'h01);
    gap_busy(5);
    send(8'h00);
    check("t4_rdy",        reg_si_rdy, 1'b1);
    check("t4_busy_issue", busy, 1'b1);
    idle(1);
    check("t4_busy_after", busy, 1'b0);
    check("t4_busy_gaps",  busy_bad, 0);
    check("t4_touts",      touts - tbase, 0);
    check("t4_strobes",    strobes - base, 1);
    check("t4_addr",       s_addr_q[base], 4'h2);
    check("t4_data",       s_data_q[base], 16'h0001);

    // Reset mid-frame
    base = strobes;
    send(8'h01);
    send(8'hFF);
    rx_rdy = 1'b0;
    rst    = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_rdy",     reg_si_rdy,  1'b0);
    check("t5_rst_busy",    busy,        1'b0);
    check("t5_rst_timeout", timeout,     1'b0);
    check("t5_rst_addr",    reg_si_addr, 4'h0);
    check("t5_rst_data",    reg_si_data, 16'h0000);
    rst = 1'b1;
    idle(2);
    check("t5_no_strobe", strobes - base, 0);
    send(8'h00);
    send(8'h10);
    send(8'h00);
    idle(2);
    check("t5_strobes", strobes - base, 1);
    check("t5_addr",    s_addr_q[base], 4'h0);
    check("t5_data",    s_data_q[base], 16'h0010);

    // Address word upper bits ignored
    base = strobes;
    send(8'hF3);
    send(8'h01);
    send(8'h00);
    idle(2);
    check("t6_strobes", strobes - base, 1);
    check("t6_addr",    reg_si_addr, 4'h3);
    check("t6_data",    reg_si_data, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
